// File: rtl/tribonacci_pkg.sv
// Shared definitions for the tribonacci generator/checker pair: checker states,
// seed terms matching the generator's reset values, and the default term width.
package tribonacci_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } trib_state_t;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] SEED0 = 32'd0;
    localparam logic [31:0] SEED1 = 32'd1;
    localparam logic [31:0] SEED2 = 32'd1;

    function automatic logic [31:0] seed_term(input logic [1:0] idx);
        logic [31:0] val;
        case (idx)
            2'd0:    val = SEED0;
            2'd1:    val = SEED1;
            2'd2:    val = SEED2;
            default: val = SEED0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/tribonacci_checker_window.sv
// Three-term sliding window (t0 oldest) with shift-enable, synchronous clear
// and the modular sum of its contents.
import tribonacci_pkg::*;

module trib_window #(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic [width-1:0] din,
    output logic [width-1:0] sum
);

    logic [width-1:0] t0_r;
    logic [width-1:0] t1_r;
    logic [width-1:0] t2_r;

    // Window registers: clear zeroes, shift pushes din in as the newest term.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t0_r <= {width{1'b0}};
            t1_r <= {width{1'b0}};
            t2_r <= {width{1'b0}};
        end else if (clear) begin
            t0_r <= {width{1'b0}};
            t1_r <= {width{1'b0}};
            t2_r <= {width{1'b0}};
        end else if (shift) begin
            t0_r <= t1_r;
            t1_r <= t2_r;
            t2_r <= din;
        end
    end

    assign sum = t0_r + t1_r + t2_r;

endmodule

// File: rtl/tribonacci_checker.sv
// Tribonacci stream checker: locks on three seed terms, then verifies each
// later term against the windowed sum and latches the first mismatch.
import tribonacci_pkg::*;

module tribonacci_checker #(
    parameter int width      = DEFAULT_WIDTH,
    parameter int cnt_width  = 16,
    parameter bit check_seed = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [width-1:0]     in_data,
    output logic                 in_ready,
    output logic                 locked,
    output logic                 error,
    output logic [width-1:0]     expected,
    output logic [width-1:0]     bad_data,
    output logic [cnt_width-1:0] err_index,
    output logic [cnt_width-1:0] term_count
);

    trib_state_t          state_r;
    logic [1:0]           seed_idx_r;
    logic [cnt_width-1:0] count_r;
    logic                 locked_r;
    logic                 error_r;
    logic [width-1:0]     bad_r;
    logic [cnt_width-1:0] eidx_r;

    logic                 accept_s;
    logic                 shift_s;
    logic                 seed_ok_s;
    logic                 match_s;
    logic [width-1:0]     seed_val_s;
    logic [width-1:0]     sum_s;
    logic [cnt_width-1:0] count_next_s;

    assign in_ready     = (state_r != FAULT) & ~clear;
    assign accept_s     = in_valid & in_ready;
    assign seed_val_s   = width'(seed_term(seed_idx_r));
    assign seed_ok_s    = (check_seed == 1'b0) || (in_data == seed_val_s);
    assign match_s      = (in_data == sum_s);
    assign count_next_s = (count_r == {cnt_width{1'b1}}) ? count_r
                                                         : count_r + cnt_width'(1);

    // Window shift: every seed term shifts; in TRACK only a matching term does,
    // so a mismatch leaves expected pointing at the required value.
    always_comb begin
        shift_s = 1'b0;
        if (accept_s) begin
            case (state_r)
                ACQ:     shift_s = 1'b1;
                TRACK:   shift_s = match_s;
                default: shift_s = 1'b0;
            endcase
        end else begin
            shift_s = 1'b0;
        end
    end

    trib_window #(.width(width)) u_window (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .shift (shift_s),
        .din   (in_data),
        .sum   (sum_s)
    );

    // FSM, saturating term counter and error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ACQ;
            seed_idx_r <= 2'd0;
            count_r    <= {cnt_width{1'b0}};
            locked_r   <= 1'b0;
            error_r    <= 1'b0;
            bad_r      <= {width{1'b0}};
            eidx_r     <= {cnt_width{1'b0}};
        end else if (clear) begin
            state_r    <= ACQ;
            seed_idx_r <= 2'd0;
            count_r    <= {cnt_width{1'b0}};
            locked_r   <= 1'b0;
            error_r    <= 1'b0;
            bad_r      <= {width{1'b0}};
            eidx_r     <= {cnt_width{1'b0}};
        end else if (accept_s) begin
            count_r <= count_next_s;
            case (state_r)
                ACQ: begin
                    if (!seed_ok_s) begin
                        state_r <= FAULT;
                        error_r <= 1'b1;
                        bad_r   <= in_data;
                        eidx_r  <= count_r;
                    end else if (seed_idx_r == 2'd2) begin
                        state_r  <= TRACK;
                        locked_r <= 1'b1;
                    end else begin
                        seed_idx_r <= seed_idx_r + 2'd1;
                    end
                end
                TRACK: begin
                    if (!match_s) begin
                        state_r <= FAULT;
                        error_r <= 1'b1;
                        bad_r   <= in_data;
                        eidx_r  <= count_r;
                    end
                end
                default: state_r <= state_r;
            endcase
        end
    end

    assign locked     = locked_r;
    assign error      = error_r;
    assign expected   = sum_s;
    assign bad_data   = bad_r;
    assign err_index  = eidx_r;
    assign term_count = count_r;

endmodule

// File: tb/tb_tribonacci_checker.sv
// Directed bench for tribonacci_checker: three instances (32-bit seeded, 8-bit
// with 4-bit counter, 32-bit unseeded) checked every cycle against a term-list model.
`timescale 1ns/1ps

module tb_tribonacci_checker;

    logic        clk;
    logic        rst;
    logic        v   [3];
    logic        clr [3];
    logic [31:0] d   [3];

    logic        rdy0, lck0, err0, rdy1, lck1, err1, rdy2, lck2, err2;
    logic [31:0] exp0, bad0, exp2, bad2;
    logic [7:0]  exp1, bad1;
    logic [15:0] eidx0, tc0, eidx2, tc2;
    logic [3:0]  eidx1, tc1;

    int checks;
    int failures;

    // Model: last three accepted good terms, good-term count, counter, error capture.
    logic [31:0] m_mask [3];
    bit          m_cs   [3];
    int          m_cmax [3];
    logic [31:0] m_win  [3][3];
    int          m_good [3];
    int          m_cnt  [3];
    bit          m_err  [3];
    logic [31:0] m_bad  [3];
    int          m_eidx [3];

    logic [31:0] clean [8]  = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd7, 32'd13, 32'd24};
    logic [31:0] seq8  [20] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd7, 32'd13, 32'd24,
                                32'd44, 32'd81, 32'd149, 32'd18, 32'd248, 32'd159, 32'd169,
                                32'd64, 32'd136, 32'd113, 32'd57, 32'd50};
    logic [31:0] seeds [3]  = '{32'd0, 32'd1, 32'd1};

    tribonacci_checker #(.width(32), .cnt_width(16), .check_seed(1'b1)) dut0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .in_valid(v[0]), .in_data(d[0]),
        .in_ready(rdy0), .locked(lck0), .error(err0), .expected(exp0),
        .bad_data(bad0), .err_index(eidx0), .term_count(tc0));

    tribonacci_checker #(.width(8), .cnt_width(4), .check_seed(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .in_valid(v[1]), .in_data(d[1][7:0]),
        .in_ready(rdy1), .locked(lck1), .error(err1), .expected(exp1),
        .bad_data(bad1), .err_index(eidx1), .term_count(tc1));

    tribonacci_checker #(.width(32), .cnt_width(16), .check_seed(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clear(clr[2]), .in_valid(v[2]), .in_data(d[2]),
        .in_ready(rdy2), .locked(lck2), .error(err2), .expected(exp2),
        .bad_data(bad2), .err_index(eidx2), .term_count(tc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s inst%0d got=%0d want=%0d", name, i, got, want);
        end
    endtask

    task automatic model_clear(input int i);
        for (int k = 0; k < 3; k++) m_win[i][k] = 32'd0;
        m_good[i] = 0;
        m_cnt[i]  = 0;
        m_err[i]  = 1'b0;
        m_bad[i]  = 32'd0;
        m_eidx[i] = 0;
    endtask

    function automatic logic [31:0] model_sum(input int i);
        return (m_win[i][0] + m_win[i][1] + m_win[i][2]) & m_mask[i];
    endfunction

    task automatic model_step(input int i);
        logic [31:0] want;
        if (clr[i]) begin
            model_clear(i);
        end else if (v[i] && !m_err[i]) begin
            if (m_good[i] < 3) want = m_cs[i] ? seeds[m_good[i]] : d[i];
            else               want = model_sum(i);
            if (d[i] == want) begin
                m_win[i][0] = m_win[i][1];
                m_win[i][1] = m_win[i][2];
                m_win[i][2] = d[i];
                if (m_good[i] < 3) m_good[i]++;
            end else begin
                m_err[i]  = 1'b1;
                m_bad[i]  = d[i];
                m_eidx[i] = m_cnt[i];
            end
            if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) for (int i = 0; i < 3; i++) model_step(i);
        #1;
    endtask

    task automatic send(input int i, input logic [31:0] val);
        v[i] = 1'b1;
        d[i] = val;
        cyc();
        v[i] = 1'b0;
    endtask

    task automatic pulse_clear(input int i);
        clr[i] = 1'b1;
        cyc();
        clr[i] = 1'b0;
    endtask

    task automatic cmp_inst(input int i, input logic r, input logic l, input logic e,
                            input logic [31:0] ex, input logic [31:0] b,
                            input logic [31:0] ei, input logic [31:0] tc);
        chk("in_ready", i, {31'd0, r}, {31'd0, !m_err[i] && !clr[i]});
        chk("locked",   i, {31'd0, l}, {31'd0, m_good[i] >= 3});
        chk("error",    i, {31'd0, e}, {31'd0, m_err[i]});
        chk("bad_data", i, b, m_bad[i]);
        chk("err_index", i, ei, m_eidx[i]);
        chk("term_count", i, tc, m_cnt[i]);
        if (m_good[i] >= 3) chk("expected", i, ex, model_sum(i));
    endtask

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, rdy0, lck0, err0, exp0, bad0, {16'd0, eidx0}, {16'd0, tc0});
            cmp_inst(1, rdy1, lck1, err1, {24'd0, exp1}, {24'd0, bad1}, {28'd0, eidx1}, {28'd0, tc1});
            cmp_inst(2, rdy2, lck2, err2, exp2, bad2, {16'd0, eidx2}, {16'd0, tc2});
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_mask = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
        m_cs   = '{1'b1, 1'b1, 1'b0};
        m_cmax = '{65535, 15, 65535};
        for (int i = 0; i < 3; i++) begin
            model_clear(i);
            v[i] = 1'b0; clr[i] = 1'b0; d[i] = 32'd0;
        end
        rst = 1'b0;
        #3;
        chk("rst_locked", 0, {31'd0, lck0}, 32'd0);
        chk("rst_error", 0, {31'd0, err0}, 32'd0);
        chk("rst_count", 0, {16'd0, tc0}, 32'd0);
        chk("rst_expected", 0, exp0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();

        // Clean stream
        for (int k = 0; k < 8; k++) begin
            send(0, clean[k]);
            if (k == 2) chk("lock_after_3", 0, {31'd0, lck0}, 32'd1);
        end
        chk("clean_error", 0, {31'd0, err0}, 32'd0);
        chk("clean_count", 0, {16'd0, tc0}, 32'd8);
        chk("clean_expected", 0, exp0, 32'd44);

        // Corrupt fifth term
        pulse_clear(0);
        for (int k = 0; k < 4; k++) send(0, clean[k]);
        send(0, 32'd5);
        chk("corrupt_error", 0, {31'd0, err0}, 32'd1);
        chk("corrupt_index", 0, {16'd0, eidx0}, 32'd4);
        chk("corrupt_bad", 0, bad0, 32'd5);
        chk("corrupt_expected", 0, exp0, 32'd4);
        chk("corrupt_ready", 0, {31'd0, rdy0}, 32'd0);
        send(0, 32'd7);
        send(0, 32'd4);
        chk("fault_no_accept", 0, {16'd0, tc0}, 32'd5);

        // Clear together with in_valid while in FAULT
        v[0] = 1'b1; d[0] = 32'd0; clr[0] = 1'b1;
        cyc();
        v[0] = 1'b0; clr[0] = 1'b0;
        chk("clear_error", 0, {31'd0, err0}, 32'd0);
        chk("clear_count", 0, {16'd0, tc0}, 32'd0);
        chk("clear_locked", 0, {31'd0, lck0}, 32'd0);
        for (int k = 0; k < 4; k++) send(0, clean[k]);
        chk("relock", 0, {31'd0, lck0}, 32'd1);
        chk("relock_count", 0, {16'd0, tc0}, 32'd4);

        // 8-bit wrap-around, then a bad last term, then counter saturation
        for (int k = 0; k < 13; k++) send(1, seq8[k]);
        chk("wrap_error", 1, {31'd0, err1}, 32'd0);
        chk("wrap_count", 1, {28'd0, tc1}, 32'd13);
        pulse_clear(1);
        for (int k = 0; k < 12; k++) send(1, seq8[k]);
        send(1, 32'd249);
        chk("wrap_bad_error", 1, {31'd0, err1}, 32'd1);
        chk("wrap_bad_index", 1, {28'd0, eidx1}, 32'd12);
        pulse_clear(1);
        for (int k = 0; k < 20; k++) send(1, seq8[k]);
        chk("sat_count", 1, {28'd0, tc1}, 32'd15);
        chk("sat_expected", 1, {24'd0, exp1}, 32'd220);
        send(1, 32'd0);
        chk("sat_err_index", 1, {28'd0, eidx1}, 32'd15);

        // Seed check on and off
        pulse_clear(0);
        send(0, 32'd1); send(0, 32'd1); send(0, 32'd2);
        chk("seed_error", 0, {31'd0, err0}, 32'd1);
        chk("seed_index", 0, {16'd0, eidx0}, 32'd0);
        chk("seed_bad", 0, bad0, 32'd1);
        send(2, 32'd1); send(2, 32'd1); send(2, 32'd2); send(2, 32'd4); send(2, 32'd7);
        chk("noseed_error", 2, {31'd0, err2}, 32'd0);
        chk("noseed_locked", 2, {31'd0, lck2}, 32'd1);
        chk("noseed_expected", 2, exp2, 32'd13);

        // Reset mid-stream
        pulse_clear(0);
        for (int k = 0; k < 5; k++) send(0, clean[k]);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        #1;
        chk("midrst_count", 0, {16'd0, tc0}, 32'd0);
        chk("midrst_locked", 0, {31'd0, lck0}, 32'd0);
        chk("midrst_expected", 0, exp0, 32'd0);
        cyc();
        rst = 1'b1;
        send(0, 32'd0); send(0, 32'd1); send(0, 32'd1);
        chk("post_rst_lock", 0, {31'd0, lck0}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        cyc();
        rst = 1'b1;
        send(0, 32'd13); send(0, 32'd24); send(0, 32'd44);
        chk("old_stream_error", 0, {31'd0, err0}, 32'd1);
        chk("old_stream_index", 0, {16'd0, eidx0}, 32'd0);
        chk("old_stream_bad", 0, bad0, 32'd13);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tribonacci_checker.md
# tribonacci_checker

Stream consumer for the tribonacci generator. It accepts one term per valid/ready transfer and locks onto the first three terms. Every later term is checked against the modular sum of the previous three, and the first mismatch is latched with diagnostics. It sits downstream of the generator, or of any link carrying its output, as a self-check and integrity monitor.

## Interface
- `width`, 32: term width in bits; all arithmetic is mod 2^width.
- `cnt_width`, 16: width of the term counter.
- `check_seed`, 1: when 1, the first three terms must be 0, 1, 1 (the generator's reset state). When 0, any three terms are accepted as the seed.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous re-arm; returns the block to acquisition.
- `in_valid`  input  1  `in_data` is valid.
- `in_data`  input  width  tribonacci term.
- `in_ready`  output  1  block accepts a term this cycle.
- `locked`  output  1  three seed terms taken, tracking active.
- `error`  output  1  sticky mismatch flag.
- `expected`  output  width  next required term (sum of the window).
- `bad_data`  output  width  offending term captured at the error.
- `err_index`  output  cnt_width  term index of the offending term (0-based).
- `term_count`  output  cnt_width  accepted terms; saturates at all-ones.

## Operation
- Transfer: a term is accepted when `in_valid` and `in_ready` are both high on a rising edge.
- `in_ready = (state != FAULT) & ~clear` (combinational).
- Window registers t0, t1, t2 (t0 oldest). `expected = t0 + t1 + t2`, truncated to `width`.
- States: ACQ, TRACK, FAULT.
- **ACQ**, using an internal seed index k in 0..2:
  - Each accepted term shifts into the window (t0←t1, t1←t2, t2←in_data).
  - If `check_seed` = 1 and the term ≠ seed[k], go to FAULT.
  - After the third accepted good term, go to TRACK and set `locked` = 1.
- **TRACK**:
  - An accepted term equal to `expected` shifts into the window.
  - An accepted term ≠ `expected` goes to FAULT. The window is held so that `expected` still shows the required value.
- **Entering FAULT**:
  - `error` = 1, `bad_data` = in_data, `err_index` = `term_count` before the increment.
  - `locked` holds its value.
  - The offending term still increments `term_count`.
- **FAULT**: no transfers (`in_ready` = 0). The state is left only via `clear` or reset.
- **clear**: from any state, go to ACQ. This zeroes the window, `term_count`, `locked`, `error`, `bad_data` and `err_index`. `clear` wins over a simultaneous `in_valid`; that term is not accepted.
- **Counter**: `term_count` increments on every accepted term and saturates at 2^cnt_width − 1. `err_index` takes the saturated value when the error occurs past saturation.

## Timing
- Reset (`rst` low, asynchronous): state = ACQ, window = 0, `term_count` = 0. `locked`, `error`, `bad_data` and `err_index` = 0.
- Reset may assert mid-stream and takes effect immediately. After release, the first accepted term is treated as seed index 0.
- All status outputs are registered:
  - `error` and `locked` change on the clock edge that accepts the deciding term, so they are visible the cycle after the transfer.
  - `expected` updates the cycle after each accepted term. It is meaningful only while `locked` = 1.
- Throughput: one term per cycle. There are no bubbles in ACQ or TRACK.
- `in_valid` may drop at any cycle; the state holds.

## Structure
- **Package `tribonacci_pkg`**:
  - State enum {ACQ, TRACK, FAULT}.
  - Seed constants SEED0 = 0, SEED1 = 1, SEED2 = 1, shared with the generator's reset values.
  - Default `width`.
- **Sub-module `trib_window`**: three `width`-bit registers with shift-enable and synchronous clear, the async active-low reset, and the combinational sum output. The checker top holds the FSM, counter and capture registers.

## Test plan
- **Clean stream**: `check_seed` = 1, width 32, stream 0,1,1,2,4,7,13,24.
  - Required: `locked` = 1 after the third term, `error` = 0, `term_count` = 8, `expected` = 44.
- **Corrupt term**: stream 0,1,1,2,5.
  - Required: `error` = 1 the cycle after, `err_index` = 4, `bad_data` = 5, `expected` = 4, `in_ready` = 0.
  - A further `in_valid` is not accepted.
- **Wrap-around**: width 8, stream 0,1,1,2,4,7,13,24,44,81,149,18,248.
  - Required: no error, `term_count` = 13.
  - Same stream with 249 as the last term: `error` = 1, `err_index` = 12.
- **Seed check**:
  - `check_seed` = 1, stream 1,1,2 → `error` at `err_index` 0, `bad_data` = 1.
  - `check_seed` = 0, stream 1,1,2,4,7 → no error, `locked` = 1.
- **Clear**: in FAULT, pulse `clear` together with `in_valid`.
  - Required: that term is not accepted; state = ACQ, `error` = 0, `term_count` = 0.
  - A subsequent 0,1,1,2 is then accepted cleanly.
- **Reset mid-stream**: assert `rst` low between terms 5 and 6.
  - Required: all outputs are 0 immediately.
  - Restarting at 0,1,1 re-locks; continuing the old stream (13,24,44) with `check_seed` = 1 faults at index 0.
